// File: rtl/avl_bus_n21.sv
// rtl/avl_bus_n21.sv - N-to-1 Avalon-style arbiter with burst lock and in-order read routing
// Optional macro AVL_BUS_N21_FIXED_PRIO_EN: lowest-index master wins instead of round-robin.
module avl_bus_n21 #(
  parameter int MASTER_NUM      = 4,
  parameter int RESP_FIFO_DEPTH = 4,
  parameter int BURST_WIDTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   rest,
  input  logic [MASTER_NUM-1:0][31:0]            avl_in_address_i,
  input  logic [MASTER_NUM-1:0][3:0]             avl_in_byte_en_i,
  input  logic [MASTER_NUM-1:0]                  avl_in_read_i,
  input  logic [MASTER_NUM-1:0]                  avl_in_write_i,
  input  logic [MASTER_NUM-1:0][31:0]            avl_in_write_data_i,
  input  logic [MASTER_NUM-1:0]                  avl_in_begin_burst_transfer_i,
  input  logic [MASTER_NUM-1:0][BURST_WIDTH-1:0] avl_in_burst_count_i,
  output logic [MASTER_NUM-1:0]                  avl_in_request_ready_o,
  output logic [MASTER_NUM-1:0][31:0]            avl_in_read_data_o,
  output logic [MASTER_NUM-1:0]                  avl_in_read_data_valid_o,
  input  logic [MASTER_NUM-1:0]                  avl_in_resp_ready_i,
  output logic [31:0]                            avl_out_address_o,
  output logic [3:0]                             avl_out_byte_en_o,
  output logic                                   avl_out_read_o,
  output logic                                   avl_out_write_o,
  output logic [31:0]                            avl_out_write_data_o,
  output logic                                   avl_out_begin_burst_transfer_o,
  output logic [BURST_WIDTH-1:0]                 avl_out_burst_count_o,
  input  logic                                   avl_out_request_ready_i,
  input  logic [31:0]                            avl_out_read_data_i,
  input  logic                                   avl_out_read_data_valid_i,
  output logic                                   avl_out_resp_ready_o
);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  // Read data is broadcast; only the valid strobe is steered.
  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) avl_in_read_data_o[i] = avl_out_read_data_i;
  end

  if (MASTER_NUM == 1) begin : g_pass
    // Single master: wires straight through, nothing to arbitrate or route.
    always_comb begin
      avl_out_address_o              = avl_in_address_i[0];
      avl_out_byte_en_o              = avl_in_byte_en_i[0];
      avl_out_read_o                 = avl_in_read_i[0];
      avl_out_write_o                = avl_in_write_i[0];
      avl_out_write_data_o           = avl_in_write_data_i[0];
      avl_out_begin_burst_transfer_o = avl_in_begin_burst_transfer_i[0];
      avl_out_burst_count_o          = avl_in_burst_count_i[0];
      avl_in_request_ready_o[0]      = avl_out_request_ready_i & ~rest;
      avl_in_read_data_valid_o[0]    = avl_out_read_data_valid_i & ~rest;
      avl_out_resp_ready_o           = avl_in_resp_ready_i[0];
    end
  end else begin : g_arb
    localparam int IDW = $clog2(MASTER_NUM);
    localparam int PW  = $clog2(RESP_FIFO_DEPTH);

    lock_state_e            state_q, state_d;
    logic [IDW-1:0]         owner_q, owner_d;
    logic [BURST_WIDTH-1:0] wcnt_q, wcnt_d;

    logic [IDW-1:0]         fifo_id_q    [RESP_FIFO_DEPTH];
    logic [BURST_WIDTH-1:0] fifo_beats_q [RESP_FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PW:0]            count_q;
    logic [BURST_WIDTH-1:0] rcnt_q;

    logic [MASTER_NUM-1:0]  req;
    logic                   sel_found;
    logic [IDW-1:0]         sel_id;
    logic                   gnt_valid;
    logic [IDW-1:0]         gnt_id;
    logic                   g_read, g_write, cmd_ready, rd_acc, wr_acc;
    logic                   fifo_empty, fifo_full, can_push, beat_done, pop;
    logic [IDW-1:0]         head_id;
    logic [BURST_WIDTH-1:0] head_beats, push_beats;

    assign req = avl_in_read_i | avl_in_write_i;

`ifdef AVL_BUS_N21_FIXED_PRIO_EN
    // Fixed priority: lowest requesting index wins.
    always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      for (int k = 0; k < MASTER_NUM; k++) begin
        if (!sel_found && req[k]) begin
          sel_found = 1'b1;
          sel_id    = IDW'(k);
        end
      end
    end
`else
    // rr_ptr holds the first index to search, i.e. last_winner + 1.
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW:0]   rr_idx;

    // Round-robin search starting at rr_ptr, wrapping modulo MASTER_NUM.
    always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      rr_idx    = '0;
      for (int k = 0; k < MASTER_NUM; k++) begin
        rr_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
        if (rr_idx >= (IDW+1)'(MASTER_NUM)) rr_idx = rr_idx - (IDW+1)'(MASTER_NUM);
        if (!sel_found && req[rr_idx[IDW-1:0]]) begin
          sel_found = 1'b1;
          sel_id    = rr_idx[IDW-1:0];
        end
      end
    end

    // Pointer only advances on commands accepted outside a locked burst.
    always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == ST_OPEN && (rd_acc || wr_acc))
        rr_ptr_d = (gnt_id == IDW'(MASTER_NUM - 1)) ? '0 : gnt_id + IDW'(1);
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rest) begin
      if (rest) rr_ptr_q <= '0;
      else      rr_ptr_q <= rr_ptr_d;
    end
`endif

    // While locked only the owner's write beats are granted.
    always_comb begin
      if (state_q == ST_LOCKED) begin
        gnt_id    = owner_q;
        gnt_valid = avl_in_write_i[owner_q];
      end else begin
        gnt_id    = sel_id;
        gnt_valid = sel_found;
      end
    end

    assign head_id    = fifo_id_q[rd_ptr_q];
    assign head_beats = fifo_beats_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(RESP_FIFO_DEPTH));
    assign beat_done  = !fifo_empty && avl_out_read_data_valid_i && avl_in_resp_ready_i[head_id];
    assign pop        = beat_done && ((rcnt_q + BURST_WIDTH'(1)) == head_beats);
    // A full FIFO still takes a read in the cycle its head entry retires.
    assign can_push   = !fifo_full || pop;

    assign g_read     = gnt_valid && (state_q == ST_OPEN) && avl_in_read_i[gnt_id];
    assign g_write    = gnt_valid && avl_in_write_i[gnt_id];
    assign cmd_ready  = avl_out_request_ready_i && (!g_read || can_push);
    assign rd_acc     = g_read && cmd_ready;
    assign wr_acc     = g_write && cmd_ready;
    assign push_beats = (avl_in_burst_count_i[gnt_id] == '0) ? BURST_WIDTH'(1)
                                                             : avl_in_burst_count_i[gnt_id];

    // Command mux, ready steering and response valid steering.
    always_comb begin
      avl_out_address_o              = '0;
      avl_out_byte_en_o              = '0;
      avl_out_read_o                 = 1'b0;
      avl_out_write_o                = 1'b0;
      avl_out_write_data_o           = '0;
      avl_out_begin_burst_transfer_o = 1'b0;
      avl_out_burst_count_o          = '0;
      avl_in_request_ready_o         = '0;
      avl_in_read_data_valid_o       = '0;
      avl_out_resp_ready_o           = 1'b0;
      if (gnt_valid) begin
        avl_out_address_o              = avl_in_address_i[gnt_id];
        avl_out_byte_en_o              = avl_in_byte_en_i[gnt_id];
        avl_out_read_o                 = g_read && can_push;
        avl_out_write_o                = g_write;
        avl_out_write_data_o           = avl_in_write_data_i[gnt_id];
        avl_out_begin_burst_transfer_o = avl_in_begin_burst_transfer_i[gnt_id];
        avl_out_burst_count_o          = avl_in_burst_count_i[gnt_id];
        if (!rest) avl_in_request_ready_o[gnt_id] = cmd_ready;
      end
      if (!fifo_empty) begin
        avl_out_resp_ready_o = avl_in_resp_ready_i[head_id];
        if (!rest) avl_in_read_data_valid_o[head_id] = avl_out_read_data_valid_i;
      end
    end

    // Burst lock next state: a multi-beat write holds the grant until its last beat.
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wcnt_d  = wcnt_q;
      case (state_q)
        ST_OPEN: begin
          if (wr_acc && avl_in_begin_burst_transfer_i[gnt_id] &&
              avl_in_burst_count_i[gnt_id] > BURST_WIDTH'(1)) begin
            state_d = ST_LOCKED;
            owner_d = gnt_id;
            wcnt_d  = avl_in_burst_count_i[gnt_id] - BURST_WIDTH'(1);
          end
        end
        ST_LOCKED: begin
          if (wr_acc) begin
            wcnt_d = wcnt_q - BURST_WIDTH'(1);
            if (wcnt_q == BURST_WIDTH'(1)) state_d = ST_OPEN;
          end
        end
        default: state_d = ST_OPEN;
      endcase
    end

    // Burst lock registers.
    always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
        state_q <= ST_OPEN;
        owner_q <= '0;
        wcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        wcnt_q  <= wcnt_d;
      end
    end

    // Response routing FIFO of {master id, beat count} plus head beat counter.
    always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        rcnt_q   <= '0;
        for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
          fifo_id_q[i]    <= '0;
          fifo_beats_q[i] <= '0;
        end
      end else begin
        if (rd_acc) begin
          fifo_id_q[wr_ptr_q]    <= gnt_id;
          fifo_beats_q[wr_ptr_q] <= push_beats;
          wr_ptr_q               <= wr_ptr_q + PW'(1);
        end
        if (beat_done) rcnt_q <= pop ? '0 : rcnt_q + BURST_WIDTH'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({rd_acc, pop})
          2'b10:   count_q <= count_q + (PW+1)'(1);
          2'b01:   count_q <= count_q - (PW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule
